// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM/port types, request payload struct and defaults for the dmem arbiter.
// Latency: none, types and a pure helper function only.
// Backpressure: not applicable.
package dmem_pkg;

  // Default RAM word-address width (2^10 words of 32 bits).
  localparam int DMEM_WORD_AW = 10;

  // Two-state access FSM: accept in IDLE, answer in RESP.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } dmem_state_e;

  // Requester identity; also the bit index into the grant vector.
  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LDR  = 1'b1
  } dmem_port_e;

  // Request payload as presented by either requester.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // True when any address bit above the RAM window is set.
  function automatic logic dmem_addr_oor(input logic [31:0] addr, input int word_aw);
    return (addr >> (word_aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arb2.sv
// dmem_arb2: two-way request arbiter producing a one-hot grant.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: a request that loses simply sees no grant; build option DMEM_ARB_RR_EN adds a priority pointer input.
module dmem_arb2 (
`ifdef DMEM_ARB_RR_EN
  input  logic       prio_ptr,  // 0: core wins a tie, 1: loader wins a tie
`endif
  input  logic [1:0] req,       // bit 0 core, bit 1 loader
  output logic [1:0] gnt        // one-hot, or zero when nothing requests
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: a lone request always wins, a tie goes to the pointed-at port.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = prio_ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end
`else
  // Fixed priority: the core wins whenever it requests.
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the core LSU and the program loader.
// Latency: request accepted combinationally in IDLE, one-cycle response pulse in the next (RESP) cycle.
// Backpressure: at most one request per two cycles; both readies are low in RESP. Build option DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WORD_AW = DMEM_WORD_AW
) (
  input  logic               clk,
  input  logic               rst,
  // core LSU, port 0
  input  logic               core_req_valid,
  output logic               core_req_ready,
  input  logic               core_req_we,
  input  logic [31:0]        core_req_addr,
  input  logic [31:0]        core_req_wdata,
  input  logic [3:0]         core_req_be,
  output logic               core_rsp_valid,
  output logic [31:0]        core_rsp_rdata,
  output logic               core_rsp_err,
  // program loader, port 1
  input  logic               ldr_req_valid,
  output logic               ldr_req_ready,
  input  logic               ldr_req_we,
  input  logic [31:0]        ldr_req_addr,
  input  logic [31:0]        ldr_req_wdata,
  input  logic [3:0]         ldr_req_be,
  output logic               ldr_rsp_valid,
  output logic [31:0]        ldr_rsp_rdata,
  output logic               ldr_rsp_err,
  // RAM
  output logic               ram_en,
  output logic               ram_we,
  output logic [WORD_AW-1:0] ram_addr,
  output logic [3:0]         ram_be,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  // FSM state and the facts about the accepted request that the response needs.
  dmem_state_e state_q, state_d;
  dmem_port_e  gnt_port_q, gnt_port_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
`ifdef DMEM_ARB_RR_EN
  // Port that wins the next tie; flips away from whoever was just served.
  logic        rr_ptr_q, rr_ptr_d;
`endif

  // Arbitration and selected-request signals.
  dmem_req_t   core_req, ldr_req, sel_req;
  logic [1:0]  arb_req, arb_gnt;
  logic        accept;
  dmem_port_e  sel_port;
  logic        sel_oor;

  // Response datapath.
  logic        rsp_fire;
  logic [31:0] rsp_rdata;

  // Bundle each requester's payload so the mux below is a single struct select.
  always_comb begin
    core_req.we    = core_req_we;
    core_req.addr  = core_req_addr;
    core_req.wdata = core_req_wdata;
    core_req.be    = core_req_be;
    ldr_req.we     = ldr_req_we;
    ldr_req.addr   = ldr_req_addr;
    ldr_req.wdata  = ldr_req_wdata;
    ldr_req.be     = ldr_req_be;
  end

  // Offer requests to the arbiter only when idle and out of reset.
  always_comb begin
    arb_req = 2'b00;
    if (!rst && (state_q == IDLE)) begin
      arb_req = {ldr_req_valid, core_req_valid};
    end
  end

  dmem_arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
    .prio_ptr (rr_ptr_q),
`endif
    .req      (arb_req),
    .gnt      (arb_gnt)
  );

  // Pick the granted port's payload and classify its address.
  always_comb begin
    accept   = |arb_gnt;
    sel_port = arb_gnt[1] ? PORT_LDR : PORT_CORE;
    sel_req  = arb_gnt[1] ? ldr_req : core_req;
    sel_oor  = dmem_addr_oor(sel_req.addr, WORD_AW);
  end

  assign core_req_ready = arb_gnt[0];
  assign ldr_req_ready  = arb_gnt[1];

  // Drive the RAM only for an accepted in-range request; otherwise keep every strobe low.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    if (accept && !sel_oor) begin
      ram_en    = 1'b1;
      ram_we    = sel_req.we;
      ram_be    = sel_req.be;
      ram_addr  = sel_req.addr[WORD_AW+1:2];
      ram_wdata = sel_req.wdata;
    end
  end

  // Next-state: capture grant/we/err on acceptance, always fall back to IDLE after RESP.
  always_comb begin
    state_d    = state_q;
    gnt_port_d = gnt_port_q;
    we_d       = we_q;
    err_d      = err_q;
`ifdef DMEM_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = RESP;
          gnt_port_d = sel_port;
          we_d       = sel_req.we;
          err_d      = sel_oor;
`ifdef DMEM_ARB_RR_EN
          rr_ptr_d   = (sel_port == PORT_CORE);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and response-context registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_port_q <= PORT_CORE;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_port_q <= gnt_port_d;
      we_q       <= we_d;
      err_q      <= err_d;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Steer the response to the registered grant; stores and errors return zero data.
  always_comb begin
    rsp_fire       = (state_q == RESP) && !rst;
    rsp_rdata      = (we_q || err_q) ? 32'd0 : ram_rdata;
    core_rsp_valid = 1'b0;
    core_rsp_err   = 1'b0;
    core_rsp_rdata = 32'd0;
    ldr_rsp_valid  = 1'b0;
    ldr_rsp_err    = 1'b0;
    ldr_rsp_rdata  = 32'd0;
    if (rsp_fire) begin
      if (gnt_port_q == PORT_LDR) begin
        ldr_rsp_valid  = 1'b1;
        ldr_rsp_err    = err_q;
        ldr_rsp_rdata  = rsp_rdata;
      end else begin
        core_rsp_valid = 1'b1;
        core_rsp_err   = err_q;
        core_rsp_rdata = rsp_rdata;
      end
    end
  end

endmodule
